prog_branch_lut: RTL and testbench
==================================

Name: prog_branch_lut

Overview:
- Runtime-writable successor to the fixed branch-offset / data-address lookup table in the 3BC processor.
- Holds ENTRIES signed or unsigned offsets, each with a valid bit. Unwritten or out-of-range indices return DEFAULT_OUT.
- Read is registered with 1-cycle latency. Data is sign- or zero-extended to OUT_W for the PC-target adder.
- Loaded by the program loader/testbench before run. Read by fetch/branch logic.

Parameters:
- ENTRIES, 16, number of table entries (power of 2 not required, >=2).
- IDX_W, 8, index width. Indices >= ENTRIES are out of range.
- DATA_W, 10, stored entry width.
- OUT_W, 16, output width, OUT_W >= DATA_W.
- SIGNED, 1: 1 = sign-extend stored data to OUT_W, 0 = zero-extend.
- DEFAULT_OUT, 1, OUT_W-bit value returned on a miss.
- CNT_W, $clog2(ENTRIES+1), width of Count.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- WrEn  in  1  write strobe.
- WrIdx  in  IDX_W  write index.
- WrData  in  DATA_W  write data.
- Clear  in  1  invalidates all entries.
- RdReq  in  1  read request.
- Index  in  IDX_W  read index.
- Out  out  OUT_W  extended lookup result.
- OutValid  out  1  pulses 1 cycle after RdReq.
- Hit  out  1  the last read found a valid in-range entry.
- Count  out  CNT_W  number of valid entries.

Behaviour:
- Reset (async, Reset_n=0):
  - All valid bits 0, all data 0.
  - Out=DEFAULT_OUT, OutValid=0, Hit=0, Count=0.
  - Takes effect immediately, including mid-read; any pending read is dropped.
  - First edge after deassertion behaves normally.
- Write: on an edge with WrEn=1 and WrIdx<ENTRIES, entry[WrIdx] takes WrData and its valid bit is set.
  - WrIdx>=ENTRIES: write ignored, no state change.
- Clear: on an edge with Clear=1, all valid bits go to 0 (data may be left as is).
  - Clear and an in-range WrEn in the same cycle: clear applies first, then the write. Only entry[WrIdx] is valid afterwards.
- Count tracks valid entries:
  - Write to an invalid entry: +1.
  - Write to a valid entry: unchanged.
  - Clear alone: 0.
  - Clear with an in-range write: 1.
  - Never exceeds ENTRIES.
- Read: on an edge with RdReq=1, register the result. Out, Hit and OutValid=1 are visible the cycle after the request.
  - Read sees table state after this edge's write/clear (write-first bypass):
    - Index==WrIdx with in-range WrEn in the same cycle: returns WrData, Hit=1.
    - Clear in the same cycle with no matching write: returns DEFAULT_OUT, Hit=0.
  - Index>=ENTRIES or entry invalid: Out=DEFAULT_OUT, Hit=0.
  - Valid entry: Out = extend(entry) and Hit=1, where extend is sign extension if SIGNED=1, else zero extension.
- RdReq=0: OutValid=0 on the next edge. Out and Hit hold their last values.
- Back-to-back RdReq is supported: one result per cycle, no stalls, no busy state.
- No combinational path from any input to any output.

Test Plan:
1. Defaults ENTRIES=16, DATA_W=10, OUT_W=16, SIGNED=1, DEFAULT_OUT=1. Reset, then RdReq with Index=0 -> next cycle Out=16'h0001, Hit=0, OutValid=1, Count=0.
2. Write idx0=10'h235 (-459), then read idx0 -> Out=16'hFE35, Hit=1, Count=1. Repeat with SIGNED=0 -> Out=16'h0235.
3. Same cycle: WrEn idx2=10'h2D2 (-302) plus RdReq Index=2 -> next cycle Out=16'hFED2, Hit=1, Count=2. Rewrite idx2 with 10'h001 -> Count stays 2, read gives 16'h0001 with Hit=1.
4. WrEn with WrIdx=20 -> Count unchanged. Read Index=20 -> Out=16'h0001, Hit=0.
5. Preload idx0, idx2, idx7. Clear together with WrEn idx5=10'h00A -> Count=1. Read idx0 -> Out=1, Hit=0. Read idx5 -> Out=16'h000A, Hit=1.
6. RdReq on consecutive cycles for idx0, idx5, idx9 -> three consecutive OutValid pulses with the matching values. Assert Reset_n=0 between clock edges mid-stream -> Out=1, OutValid=0, Hit=0, Count=0 immediately, with no edge required.

Source files
------------

// File: rtl/prog_branch_lut.sv
// prog_branch_lut: runtime-writable branch-offset / data-address lookup table.
// Each entry holds a DATA_W-bit offset and a valid bit. A registered read
// returns the entry extended to OUT_W bits (sign or zero), or DEFAULT_OUT on
// a miss (invalid entry or index >= ENTRIES).
//
// Ports:
//   Clk       clock, rising edge
//   Reset_n   asynchronous active-low reset
//   WrEn      write strobe; WrIdx/WrData give entry index and value
//   Clear     invalidates every entry (an in-range write on the same edge wins)
//   RdReq     read request; Index is the entry to look up
//   Out       extended lookup result, updated one cycle after RdReq
//   OutValid  one-cycle pulse following each RdReq
//   Hit       last read found a valid in-range entry
//   Count     number of valid entries
module prog_branch_lut #(
    parameter int unsigned       ENTRIES     = 16,
    parameter int unsigned       IDX_W       = 8,
    parameter int unsigned       DATA_W      = 10,
    parameter int unsigned       OUT_W       = 16,
    parameter int unsigned       SIGNED      = 1,
    parameter logic [OUT_W-1:0]  DEFAULT_OUT = OUT_W'(1),
    parameter int unsigned       CNT_W       = $clog2(ENTRIES + 1)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              WrEn,
    input  logic [IDX_W-1:0]  WrIdx,
    input  logic [DATA_W-1:0] WrData,
    input  logic              Clear,
    input  logic              RdReq,
    input  logic [IDX_W-1:0]  Index,
    output logic [OUT_W-1:0]  Out,
    output logic              OutValid,
    output logic              Hit,
    output logic [CNT_W-1:0]  Count
);

    localparam int unsigned AW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [DATA_W-1:0] mem [ENTRIES];
    logic [ENTRIES-1:0] valid;

    logic              wr_ok;
    logic              rd_in_range;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic              rd_hit;
    logic [DATA_W-1:0] rd_data;
    logic [OUT_W-1:0]  rd_ext;
    logic [CNT_W-1:0]  count_d;

    // Address decode and range checks
    always_comb begin
        wr_ok       = WrEn && (32'(WrIdx) < ENTRIES);
        rd_in_range = 32'(Index) < ENTRIES;
        wr_addr     = AW'(WrIdx);
        rd_addr     = AW'(Index);
    end

    // Lookup sees the table as it will be after this edge's clear/write
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        if (wr_ok && (Index == WrIdx)) begin
            rd_hit  = 1'b1;
            rd_data = WrData;
        end else if (Clear) begin
            rd_hit  = 1'b0;
        end else if (rd_in_range && valid[rd_addr]) begin
            rd_hit  = 1'b1;
            rd_data = mem[rd_addr];
        end
    end

    // Extension to the adder width, or the miss value
    always_comb begin
        rd_ext = DEFAULT_OUT;
        if (rd_hit) begin
            if (SIGNED != 0) begin
                rd_ext = OUT_W'($signed(rd_data));
            end else begin
                rd_ext = OUT_W'(rd_data);
            end
        end
    end

    // Valid-entry count: clear restarts from zero, write may add one
    always_comb begin
        count_d = Count;
        if (Clear) begin
            count_d = wr_ok ? CNT_W'(1) : CNT_W'(0);
        end else if (wr_ok && !valid[wr_addr]) begin
            count_d = Count + CNT_W'(1);
        end
    end

    // Table storage and valid bits
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            valid <= '0;
            mem   <= '{default: '0};
            Count <= '0;
        end else begin
            if (Clear) begin
                valid <= '0;
            end
            if (wr_ok) begin
                mem[wr_addr]   <= WrData;
                valid[wr_addr] <= 1'b1;
            end
            Count <= count_d;
        end
    end

    // Registered read port; Out and Hit hold between requests
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Out      <= DEFAULT_OUT;
            OutValid <= 1'b0;
            Hit      <= 1'b0;
        end else begin
            OutValid <= RdReq;
            if (RdReq) begin
                Out <= rd_ext;
                Hit <= rd_hit;
            end
        end
    end

endmodule

// File: tb/tb_prog_branch_lut.sv
// Self-checking bench for prog_branch_lut: two instances (sign- and
// zero-extending) share stimulus and are compared against a table model.
module tb_prog_branch_lut;

    localparam int unsigned ENTRIES = 16;
    localparam int unsigned IDX_W   = 8;
    localparam int unsigned DATA_W  = 10;
    localparam int unsigned OUT_W   = 16;
    localparam int unsigned CNT_W   = 5;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              WrEn;
    logic [IDX_W-1:0]  WrIdx;
    logic [DATA_W-1:0] WrData;
    logic              Clear;
    logic              RdReq;
    logic [IDX_W-1:0]  Index;

    logic [OUT_W-1:0]  out_s, out_u;
    logic              ov_s, ov_u, hit_s, hit_u;
    logic [CNT_W-1:0]  cnt_s, cnt_u;

    always #5 Clk = ~Clk;

    prog_branch_lut #(.SIGNED(1)) dut_s (
        .Clk(Clk), .Reset_n(Reset_n), .WrEn(WrEn), .WrIdx(WrIdx),
        .WrData(WrData), .Clear(Clear), .RdReq(RdReq), .Index(Index),
        .Out(out_s), .OutValid(ov_s), .Hit(hit_s), .Count(cnt_s)
    );

    prog_branch_lut #(.SIGNED(0)) dut_u (
        .Clk(Clk), .Reset_n(Reset_n), .WrEn(WrEn), .WrIdx(WrIdx),
        .WrData(WrData), .Clear(Clear), .RdReq(RdReq), .Index(Index),
        .Out(out_u), .OutValid(ov_u), .Hit(hit_u), .Count(cnt_u)
    );

    // Reference model state
    int          m_data  [ENTRIES];
    bit          m_valid [ENTRIES];
    logic [15:0] exp_out_s, exp_out_u;
    bit          exp_hit, exp_ov;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Two's-complement or plain interpretation of a DATA_W value, as 16 bits
    function automatic logic [15:0] extend(input int d, input bit sgn);
        int v;
        v = d;
        if (sgn && d >= (1 << (DATA_W - 1))) v = d - (1 << DATA_W);
        return 16'(v);
    endfunction

    function automatic int model_count();
        int c;
        c = 0;
        for (int i = 0; i < ENTRIES; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = 0;
        end
        exp_out_s = 16'h0001;
        exp_out_u = 16'h0001;
        exp_hit   = 1'b0;
        exp_ov    = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_s"}, 32'(out_s), 32'(exp_out_s));
        check({tag, ".out_u"}, 32'(out_u), 32'(exp_out_u));
        check({tag, ".hit"},   32'(hit_s), 32'(exp_hit));
        check({tag, ".hit_u"}, 32'(hit_u), 32'(exp_hit));
        check({tag, ".ov"},    32'(ov_s),  32'(exp_ov));
        check({tag, ".cnt"},   32'(cnt_s), 32'(model_count()));
        check({tag, ".cnt_u"}, 32'(cnt_u), 32'(model_count()));
    endtask

    // Drive one cycle of stimulus (called just after a rising edge), then
    // sample #1 after the next edge and compare with the model
    task automatic step(input string tag, input bit we, input int widx, input int wdata,
                        input bit clr, input bit rd, input int ridx);
        WrEn   = we;
        WrIdx  = IDX_W'(widx);
        WrData = DATA_W'(wdata);
        Clear  = clr;
        RdReq  = rd;
        Index  = IDX_W'(ridx);
        @(posedge Clk);
        #1;
        if (clr) for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        if (we && widx < ENTRIES) begin
            m_data[widx]  = wdata;
            m_valid[widx] = 1'b1;
        end
        exp_ov = rd;
        if (rd) begin
            exp_hit   = (ridx < ENTRIES) && m_valid[ridx];
            exp_out_s = exp_hit ? extend(m_data[ridx], 1'b1) : 16'h0001;
            exp_out_u = exp_hit ? extend(m_data[ridx], 1'b0) : 16'h0001;
        end
        check_all(tag);
    endtask

    initial begin
        Reset_n = 1'b0;
        WrEn = 1'b0; WrIdx = '0; WrData = '0; Clear = 1'b0; RdReq = 1'b0; Index = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_all("reset");
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // Miss after reset
        step("t1_read0", 0, 0, 0, 0, 1, 0);
        // Negative entry, both extensions
        step("t2_wr0", 1, 0, 'h235, 0, 0, 0);
        step("t2_rd0", 0, 0, 0, 0, 1, 0);
        // Same-cycle write and read, then rewrite
        step("t3_wrrd2", 1, 2, 'h2D2, 0, 1, 2);
        step("t3_rewr2", 1, 2, 'h001, 0, 0, 0);
        step("t3_rd2", 0, 0, 0, 0, 1, 2);
        // Out-of-range write and read
        step("t4_wr20", 1, 20, 'h3FF, 0, 0, 0);
        step("t4_rd20", 0, 0, 0, 0, 1, 20);
        step("t4_rd255", 1, 255, 'h155, 0, 1, 255);
        // Clear combined with a write
        step("t5_wr7", 1, 7, 'h1C3, 0, 0, 0);
        step("t5_clrwr5", 1, 5, 'h00A, 1, 0, 0);
        step("t5_rd0", 0, 0, 0, 0, 1, 0);
        step("t5_rd5", 0, 0, 0, 0, 1, 5);
        // Clear with a non-matching write and same-cycle read of a cleared entry
        step("t5_wr3", 1, 3, 'h077, 0, 0, 0);
        step("t5_clrrd3", 1, 9, 'h012, 1, 1, 3);
        step("t5_wr5b", 1, 5, 'h00A, 1, 0, 0);
        // Hold behaviour with RdReq low
        step("hold", 0, 0, 0, 0, 0, 0);
        // Back-to-back reads
        step("t6_rd0", 0, 0, 0, 0, 1, 0);
        step("t6_rd5", 0, 0, 0, 0, 1, 5);
        step("t6_rd9", 0, 0, 0, 0, 1, 9);
        step("t6_rd5b", 0, 0, 0, 0, 1, 5);

        // Asynchronous reset between edges with a read pending
        RdReq = 1'b1; Index = IDX_W'(5);
        #2;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_async_rst");
        @(posedge Clk);
        #1;
        check_all("t6_rst_hold");
        @(negedge Clk);
        Reset_n = 1'b1;
        RdReq = 1'b0;
        @(posedge Clk);
        #1;
        exp_ov = 1'b0;
        check_all("t6_after_rst");
        step("t6_rd5_post", 0, 0, 0, 0, 1, 5);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bit we, clr, rd;
            int widx, ridx, wdata;
            we    = ($urandom_range(0, 1) == 1);
            clr   = ($urandom_range(0, 15) == 0);
            rd    = ($urandom_range(0, 3) != 0);
            widx  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 255)) : int'($urandom_range(0, 15));
            ridx  = ($urandom_range(0, 3) == 0) ? widx : int'($urandom_range(0, 19));
            wdata = int'($urandom_range(0, 1023));
            step("rand", we, widx, wdata, clr, rd, ridx);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
